// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: received-word bus from the UART framer to its CPU-side consumer
interface uart_rx_frame_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] rx_data;
  logic rx_valid;
  logic parity_err;
  logic frame_err;
  logic busy;
  modport master(output rx_data, rx_valid, parity_err, frame_err, busy);
  modport slave(input rx_data, rx_valid, parity_err, frame_err, busy);
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receive framer sampling mid-bit, LSB-first, with optional parity and stop check
module uart_rx_frame #(
  parameter int DATA_BITS = 8,
  parameter bit PARITY_EN = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic end_half_time,
  input  logic end_bit_time,
  output logic bit_rate_en,
  output logic bit_cnt_clr,
  uart_rx_frame_if.master rx_if
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
  state_t state, nxt;
  logic rx_m, rx_s, rx_s_d, par_bit, fall, stop_hit, unused_ebt;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0] idx;
  assign fall = rx_s_d & ~rx_s;
  assign stop_hit = state == STOP && end_half_time;
  assign unused_ebt = end_bit_time;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = fall ? START : IDLE;
      START:   nxt = !end_half_time ? START : rx_s ? IDLE : DATA;
      DATA:    nxt = !(end_half_time && idx == 4'(DATA_BITS - 1)) ? DATA : PARITY_EN ? PARITY : STOP;
      PARITY:  nxt = end_half_time ? STOP : PARITY;
      STOP:    nxt = !end_half_time ? STOP : rx_s ? IDLE : BRK;
      default: nxt = rx_s ? IDLE : BRK;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {rx_m, rx_s, rx_s_d} <= 3'b111;
      rx_if.rx_data <= '0;
      rx_if.rx_valid <= 1'b0;
      rx_if.parity_err <= 1'b0;
      rx_if.frame_err <= 1'b0;
      rx_if.busy <= 1'b0;
      bit_rate_en <= 1'b0;
      bit_cnt_clr <= 1'b1;
    end else begin
      {rx_m, rx_s, rx_s_d} <= {rx, rx_m, rx_s};
      state <= nxt;
      rx_if.busy <= nxt != IDLE;
      bit_rate_en <= nxt inside {START, DATA, PARITY, STOP};
      bit_cnt_clr <= nxt inside {IDLE, BRK};
      rx_if.rx_valid <= stop_hit;
      rx_if.parity_err <= stop_hit & PARITY_EN & (^shreg ^ par_bit ^ PARITY_ODD);
      rx_if.frame_err <= stop_hit & ~rx_s;
      if (stop_hit) rx_if.rx_data <= shreg;
    end
  end
  // Datapath needs no reset: every frame overwrites it completely
  always_ff @(posedge clk) begin
    if (state == START && end_half_time) idx <= 4'd0;
    if (state == DATA && end_half_time) begin
      shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      idx <= idx + 4'd1;
    end
    if (state == PARITY && end_half_time) par_bit <= rx_s;
  end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: drives 8E1 and 7N1 framers with a 16-clock bit-rate generator model
module tb_uart_rx_frame;
  typedef struct packed {logic [8:0] d; logic pe; logic fe;} res_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxl[2];
  logic en[2];
  logic clr[2];
  logic eh[2];
  logic eb[2];
  logic [3:0] cnt[2];
  int passed = 0;
  int total = 0;
  int stray = 0;
  res_t got0[$];
  res_t got1[$];

  uart_rx_frame_if #(.DATA_BITS(8)) b8();
  uart_rx_frame_if #(.DATA_BITS(7)) b7();

  uart_rx_frame #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) d8 (
    .clk(clk), .rst(rst), .rx(rxl[0]), .end_half_time(eh[0]), .end_bit_time(eb[0]),
    .bit_rate_en(en[0]), .bit_cnt_clr(clr[0]), .rx_if(b8.master));
  uart_rx_frame #(.DATA_BITS(7), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) d7 (
    .clk(clk), .rst(rst), .rx(rxl[1]), .end_half_time(eh[1]), .end_bit_time(eb[1]),
    .bit_rate_en(en[1]), .bit_cnt_clr(clr[1]), .rx_if(b7.master));

  always #5 clk = ~clk;

  // Bit-rate generator: 16 clocks per bit, mid-bit pulse at count 7
  always_ff @(posedge clk)
    for (int i = 0; i < 2; i++) cnt[i] <= (rst || clr[i] || !en[i]) ? 4'd0 : cnt[i] + 4'd1;
  always_comb
    for (int i = 0; i < 2; i++) begin
      eh[i] = en[i] && !clr[i] && cnt[i] == 4'd7;
      eb[i] = en[i] && !clr[i] && cnt[i] == 4'd15;
    end

  always @(negedge clk) begin
    if (b8.rx_valid) got0.push_back('{9'(b8.rx_data), b8.parity_err, b8.frame_err});
    else if (b8.parity_err || b8.frame_err) stray++;
    if (b7.rx_valid) got1.push_back('{9'(b7.rx_data), b7.parity_err, b7.frame_err});
    else if (b7.parity_err || b7.frame_err) stray++;
  end

  function automatic res_t model(input int u, input logic [8:0] d, input logic p, input logic st);
    res_t r;
    int nb = (u == 0) ? 8 : 7;
    r.d = d & ((9'd1 << nb) - 9'd1);
    r.pe = (u == 0) && (($countones(r.d) + int'(p)) % 2 != 0);
    r.fe = !st;
    return r;
  endfunction

  function automatic logic even_par(input logic [8:0] d);
    return ($countones(d[7:0]) % 2) != 0;
  endfunction

  task automatic drive_bit(input int u, input logic b);
    rxl[u] = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic send(input int u, input logic [8:0] d, input logic p, input logic st);
    drive_bit(u, 1'b0);
    for (int i = 0; i < ((u == 0) ? 8 : 7); i++) drive_bit(u, d[i]);
    if (u == 0) drive_bit(u, p);
    drive_bit(u, st);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({b8.rx_data, b8.rx_valid, b8.parity_err, b8.frame_err, b8.busy} !== 12'h000)
      $display("FAIL reset_outs: got %h exp 000", {b8.rx_data, b8.rx_valid, b8.parity_err, b8.frame_err, b8.busy});
    else passed++;
    total++;
    if ({en[0], clr[0], en[1], clr[1]} !== 4'b0101)
      $display("FAIL reset_gen_ctl: got %b exp 0101", {en[0], clr[0], en[1], clr[1]});
    else passed++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_good_frame;
    res_t r;
    res_t e = model(0, 9'h0A5, 1'b0, 1'b1);
    send(0, 9'h0A5, 1'b0, 1'b1);
    total++;
    if (got0.size() !== 1) $display("FAIL good_strobes: got %0d exp 1", got0.size());
    else begin
      passed++;
      r = got0.pop_front();
      total++;
      if (r !== e) $display("FAIL good_frame: got %h exp %h", r, e); else passed++;
    end
    total++;
    if ({b8.busy, clr[0], b8.rx_data} !== {2'b01, 8'hA5})
      $display("FAIL good_after: got %h exp %h", {b8.busy, clr[0], b8.rx_data}, {2'b01, 8'hA5});
    else passed++;
    drive_bit(0, 1'b1);
  endtask

  task automatic test_parity_err;
    res_t r;
    res_t e = model(0, 9'h0A5, 1'b1, 1'b1);
    send(0, 9'h0A5, 1'b1, 1'b1);
    total++;
    if (got0.size() !== 1) $display("FAIL perr_strobes: got %0d exp 1", got0.size());
    else begin
      passed++;
      r = got0.pop_front();
      total++;
      if (r !== e || r.pe !== 1'b1) $display("FAIL perr_frame: got %h exp %h", r, e); else passed++;
    end
    drive_bit(0, 1'b1);
  endtask

  task automatic test_break;
    res_t r;
    res_t e = model(0, 9'h03C, 1'b0, 1'b0);
    send(0, 9'h03C, 1'b0, 1'b0);
    repeat (39 * 16) @(negedge clk);
    total++;
    if (got0.size() !== 1) $display("FAIL brk_strobes: got %0d exp 1", got0.size());
    else begin
      passed++;
      r = got0.pop_front();
      total++;
      if (r !== e || r.fe !== 1'b1) $display("FAIL brk_frame: got %h exp %h", r, e); else passed++;
    end
    total++;
    if ({b8.busy, en[0], clr[0]} !== 3'b101)
      $display("FAIL brk_hold: got %b exp 101", {b8.busy, en[0], clr[0]});
    else passed++;
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    total++;
    if (b8.busy !== 1'b0) $display("FAIL brk_release: got %b exp 0", b8.busy); else passed++;
    e = model(0, 9'h055, even_par(9'h055), 1'b1);
    send(0, 9'h055, even_par(9'h055), 1'b1);
    total++;
    if (got0.size() !== 1) $display("FAIL brk_next_strobes: got %0d exp 1", got0.size());
    else begin
      passed++;
      r = got0.pop_front();
      total++;
      if (r !== e) $display("FAIL brk_next_frame: got %h exp %h", r, e); else passed++;
    end
    drive_bit(0, 1'b1);
  endtask

  task automatic test_glitch;
    rxl[0] = 1'b0;
    repeat (4) @(negedge clk);
    rxl[0] = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({b8.busy, clr[0]} !== 2'b10) $display("FAIL glitch_start: got %b exp 10", {b8.busy, clr[0]}); else passed++;
    repeat (24) @(negedge clk);
    total++;
    if ({b8.busy, clr[0], en[0]} !== 3'b010)
      $display("FAIL glitch_idle: got %b exp 010", {b8.busy, clr[0], en[0]});
    else passed++;
    total++;
    if (got0.size() !== 0) $display("FAIL glitch_strobes: got %0d exp 0", got0.size()); else passed++;
  endtask

  task automatic test_reset_mid;
    res_t r;
    res_t e = model(0, 9'h00F, even_par(9'h00F), 1'b1);
    logic [7:0] v = 8'hF0;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, v[i]);
    rxl[0] = v[3];
    repeat (4) @(negedge clk);
    rst = 1'b1;
    rxl[0] = 1'b1;
    @(negedge clk);
    total++;
    if ({b8.rx_data, b8.rx_valid, b8.parity_err, b8.frame_err, b8.busy, en[0], clr[0]} !== 14'h0001)
      $display("FAIL rstmid_outs: got %h exp 0001",
               {b8.rx_data, b8.rx_valid, b8.parity_err, b8.frame_err, b8.busy, en[0], clr[0]});
    else passed++;
    rst = 1'b0;
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    total++;
    if (got0.size() !== 0) $display("FAIL rstmid_strobes: got %0d exp 0", got0.size()); else passed++;
    send(0, 9'h00F, even_par(9'h00F), 1'b1);
    total++;
    if (got0.size() !== 1) $display("FAIL rstmid_next_strobes: got %0d exp 1", got0.size());
    else begin
      passed++;
      r = got0.pop_front();
      total++;
      if (r !== e) $display("FAIL rstmid_next_frame: got %h exp %h", r, e); else passed++;
    end
    drive_bit(0, 1'b1);
  endtask

  task automatic test_back_to_back;
    res_t r;
    res_t e[$];
    int n;
    for (int u = 0; u < 2; u++) begin
      e = '{model(u, 9'h000, 1'b0, 1'b1), model(u, 9'h1FF, even_par(9'h0FF), 1'b1)};
      send(u, 9'h000, 1'b0, 1'b1);
      send(u, 9'h1FF, even_par(9'h0FF), 1'b1);
      drive_bit(u, 1'b1);
      n = (u == 0) ? got0.size() : got1.size();
      total++;
      if (n !== 2) $display("FAIL b2b_strobes_u%0d: got %0d exp 2", u, n);
      else begin
        passed++;
        for (int k = 0; k < 2; k++) begin
          r = (u == 0) ? got0.pop_front() : got1.pop_front();
          total++;
          if (r !== e[k]) $display("FAIL b2b_frame_u%0d_%0d: got %h exp %h", u, k, r, e[k]); else passed++;
        end
      end
    end
  endtask

  task automatic test_random;
    res_t r;
    res_t e;
    int u, n;
    logic [8:0] d;
    logic p, st;
    for (int k = 0; k < 24; k++) begin
      u = int'($urandom_range(0, 1));
      d = 9'($urandom);
      p = even_par(d) ^ ($urandom_range(0, 3) == 0);
      st = $urandom_range(0, 4) != 0;
      e = model(u, d, p, st);
      send(u, d, p, st);
      drive_bit(u, 1'b1);
      drive_bit(u, 1'b1);
      n = (u == 0) ? got0.size() : got1.size();
      total++;
      if (n !== 1) $display("FAIL rand_strobes_%0d: got %0d exp 1", k, n);
      else begin
        passed++;
        r = (u == 0) ? got0.pop_front() : got1.pop_front();
        total++;
        if (r !== e) $display("FAIL rand_frame_%0d_u%0d: got %h exp %h", k, u, r, e); else passed++;
      end
    end
  endtask

  initial begin
    rxl[0] = 1'b1;
    rxl[1] = 1'b1;
    test_reset;
    test_good_frame;
    test_parity_err;
    test_break;
    test_glitch;
    test_reset_mid;
    test_back_to_back;
    test_random;
    total++;
    if (stray !== 0) $display("FAIL stray_flags: got %0d exp 0", stray); else passed++;
    total++;
    if (got0.size() + got1.size() !== 0)
      $display("FAIL extra_strobes: got %0d exp 0", got0.size() + got1.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
